// File: rtl/odo_sbox_prog_if.sv
// Lookup and programming bus of the Odo programmable S-box.
// master drives indices, programming stream and swap; slave is the S-box.
interface odo_sbox_prog_if #(
  parameter int unsigned WIDTH = 6,
  parameter int unsigned LANES = 4
);
  logic                   in_valid;
  logic [LANES*WIDTH-1:0] in;
  logic                   out_valid;
  logic [LANES*WIDTH-1:0] out;
  logic                   prog_valid;
  logic                   prog_ready;
  logic [WIDTH-1:0]       prog_data;
  logic                   swap;
  logic                   shadow_full;
  logic                   table_ok;

  modport master (
    output in_valid, in, prog_valid, prog_data, swap,
    input  out_valid, out, prog_ready, shadow_full, table_ok
  );

  modport slave (
    input  in_valid, in, prog_valid, prog_data, swap,
    output out_valid, out, prog_ready, shadow_full, table_ok
  );
endinterface

// File: rtl/odo_sbox_prog.sv
// Double-banked, multi-lane S-box. The active bank serves LANES lookups per
// cycle; the shadow bank is streamed in order and exchanged by a swap command.
module odo_sbox_prog #(
  parameter int unsigned WIDTH = 6,
  parameter int unsigned LANES = 4
) (
  input logic            clk,
  input logic            rst_n,
  odo_sbox_prog_if.slave bus
);
  localparam int unsigned Depth = 1 << WIDTH;

  // Table storage; deliberately not reset.
  logic [WIDTH-1:0] bank_q [2][Depth];

  logic                   bsel_q, bsel_d;
  logic [WIDTH-1:0]       wptr_q, wptr_d;
  logic                   full_q, full_d;
  logic                   ok_q, ok_d;
  logic                   out_valid_q;
  logic [LANES*WIDTH-1:0] out_q;

  logic accept;
  logic swap_ok;

  // Handshake decode: swap only counts once the shadow was already full.
  always_comb begin
    accept  = bus.prog_valid && !full_q;
    swap_ok = bus.swap && full_q;
  end

  // Next-state for bank select, write pointer and status flags.
  always_comb begin
    bsel_d = bsel_q ^ swap_ok;
    ok_d   = ok_q | swap_ok;
    wptr_d = wptr_q;
    full_d = full_q;
    if (accept) begin
      wptr_d = wptr_q + 1'b1;
      if (&wptr_q) begin
        full_d = 1'b1;
      end
    end
    // accept and swap_ok are mutually exclusive (one needs full, one !full).
    if (swap_ok) begin
      full_d = 1'b0;
    end
  end

  // Control state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bsel_q <= 1'b0;
      wptr_q <= '0;
      full_q <= 1'b0;
      ok_q   <= 1'b0;
    end else begin
      bsel_q <= bsel_d;
      wptr_q <= wptr_d;
      full_q <= full_d;
      ok_q   <= ok_d;
    end
  end

  // Shadow bank write; never touches the bank currently serving lookups.
  always_ff @(posedge clk) begin
    if (accept) begin
      bank_q[~bsel_q][wptr_q] <= bus.prog_data;
    end
  end

  // Registered lookups; a swap on this edge still reads the old active bank.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_q       <= '0;
      out_valid_q <= 1'b0;
    end else begin
      out_valid_q <= bus.in_valid;
      for (int k = 0; k < LANES; k++) begin
        out_q[k*WIDTH +: WIDTH] <= bank_q[bsel_q][bus.in[k*WIDTH +: WIDTH]];
      end
    end
  end

  // Output drive.
  always_comb begin
    bus.out         = out_q;
    bus.out_valid   = out_valid_q;
    bus.prog_ready  = ~full_q;
    bus.shadow_full = full_q;
    bus.table_ok    = ok_q;
  end
endmodule

// File: doc/odo_sbox_prog.md
# odo_sbox_prog

Programmable, multi-lane S-box lookup for the Odo round datapath. It holds two tables of 2^WIDTH entries, each WIDTH bits wide: an active bank that serves LANES parallel lookups per cycle, and a shadow bank that is streamed in through a ready/valid port. A swap command exchanges the two banks between lookups, so the per-epoch S-box can change without stalling the hash pipeline.

## Interface
- WIDTH, 6, index and data width of one entry; each table holds 2^WIDTH entries.
- LANES, 4, number of independent lookups per cycle.
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  the lookup bus carries valid indices this cycle.
- in  in  LANES*WIDTH  lookup indices; lane k occupies bits [k*WIDTH +: WIDTH].
- out_valid  out  1  registered copy of in_valid.
- out  out  LANES*WIDTH  registered lookup results, laid out lane-for-lane like in.
- prog_valid  in  1  prog_data is valid.
- prog_ready  out  1  the shadow bank accepts an entry.
- prog_data  in  WIDTH  next shadow entry, written in ascending index order.
- swap  in  1  single-cycle request to exchange active and shadow banks.
- shadow_full  out  1  all 2^WIDTH shadow entries have been written.
- table_ok  out  1  the active bank holds a fully programmed table.

## Operation
- Storage: two banks, bank[0] and bank[1]. A select register bsel names the active bank; the shadow bank is bank[~bsel]. The implementation may replicate storage per lane to give LANES read ports. Table contents are not reset.
- Lookup: every cycle, out[k] <= bank[bsel][in[k]] for every k, and out_valid <= in_valid.
  - out updates every cycle, whatever in_valid is. Consumers qualify out with out_valid.
  - Lanes are independent. Identical indices on several lanes are legal.
- Programming:
  - A WIDTH-bit write pointer wptr addresses the shadow bank.
  - An entry is accepted when prog_valid && prog_ready. On acceptance, bank[~bsel][wptr] <= prog_data and wptr increments.
  - Accepting an entry at wptr == 2^WIDTH-1 wraps wptr to 0 and sets shadow_full.
  - prog_ready = ~shadow_full. Entries offered while shadow_full is set are not accepted and not written.
- Swap: swap is honoured only when shadow_full is already 1 at the clock edge.
  - On a honoured swap: bsel toggles, shadow_full clears, and table_ok sets and stays set until reset.
  - A swap while shadow_full is 0 is ignored and not remembered.
- The newly exposed shadow bank (the old active bank) keeps stale data until it is reprogrammed from index 0.

## Timing
- Reset (rst_n low, asynchronous): out = 0, out_valid = 0, bsel = 0, wptr = 0, shadow_full = 0, table_ok = 0, prog_ready = 1.
- Lookup latency is one cycle.
- A lookup sampled on the same edge as a honoured swap reads the old active bank. Lookups on the next edge read the new bank.
- Last shadow entry and swap on the same edge: the entry is written and shadow_full sets, but the swap is ignored because shadow_full was 0 when sampled. The earliest honoured swap is one cycle later.
- prog_ready drops on the cycle after the last entry is accepted. It rises on the cycle after a honoured swap.
- Programming and lookups run concurrently with no interaction, because writes only target the shadow bank.
- Reset mid-programming discards the partial load: wptr returns to 0 and shadow_full to 0. bsel returns to 0 and table_ok to 0. Bank contents are undefined until reprogrammed.
- Before the first honoured swap, out_valid still follows in_valid, but out data is undefined. table_ok = 0 flags this.

## Test plan
- Reset values: assert rst_n low mid-cycle -> all outputs go to their reset values immediately, before the next edge, and prog_ready = 1.
- Load and swap: stream the 64 entries 0x05, 0x2a, 0x03, … 0x0e (WIDTH = 6), then pulse swap -> shadow_full falls and table_ok rises. Lookups of lanes {0, 1, 63, 31} return {0x05, 0x2a, 0x0e, 0x3f} one cycle later with out_valid = 1.
- Overflow: with shadow_full = 1, hold prog_valid with data 0x3f -> prog_ready = 0, no write occurs, and table contents are unchanged after the swap.
- Swap boundary: drive continuous lookups of index 0 while swapping to a second table whose entry 0 = 0x11 -> the lookup sampled at the swap edge returns 0x05, and the next one returns 0x11. A swap on the same edge as the last write is ignored; a swap one cycle later is honoured.
- Ignored swap: pulse swap after only 10 entries -> bsel unchanged and table_ok unchanged. The remaining 54 entries are still accepted, and wptr wraps to 0.
- Reset mid-load: write 20 entries, pulse rst_n low, then write 64 fresh entries and swap -> shadow_full sets only after exactly 64 accepts, and all lookups match the fresh table.
